// File: rtl/tx_frame_serializer_if.sv
// Handshake and data bundle between the frame serializer, its packet FIFO,
// the register file (start/pkt_len) and the downstream bit consumer.
interface tx_frame_serializer_if;
  logic       start;
  logic [7:0] pkt_len;
  logic       fifo_rd_en;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       tx_bit;
  logic       tx_bit_valid;
  logic       tx_bit_ready;
  logic       busy;
  logic       done;
  logic       underrun;
  logic       len_err;

  // Serializer side
  modport master (
    input  start, pkt_len, fifo_data, fifo_empty, tx_bit_ready,
    output fifo_rd_en, tx_bit, tx_bit_valid, busy, done, underrun, len_err
  );

  // Environment side (register file, FIFO, downstream consumer)
  modport slave (
    output start, pkt_len, fifo_data, fifo_empty, tx_bit_ready,
    input  fifo_rd_en, tx_bit, tx_bit_valid, busy, done, underrun, len_err
  );
endinterface

// File: rtl/tx_frame_serializer.sv
// Frame serializer: preamble, SFD, length, payload pulled from the FIFO and a
// CRC-8 over length+payload, shifted out MSB-first over a valid/ready bit link.
module tx_frame_serializer #(
  parameter int unsigned PREAMBLE_BYTES = 4,
  parameter logic [7:0]  SFD            = 8'hA7,
  parameter logic [7:0]  CRC_POLY       = 8'h07,
  parameter int unsigned MAX_LEN        = 64
) (
  input logic                   clk,
  input logic                   reset,
  tx_frame_serializer_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_LEN, ST_FETCH,
    ST_WAIT, ST_PAYLOAD, ST_CRC, ST_FIN
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [3:0] PRE_LAST      = 4'(PREAMBLE_BYTES - 1);
  localparam logic [7:0] MAX_LEN_B     = 8'(MAX_LEN);

  state_t     state_reg, state_next;
  logic [7:0] shreg_reg, shreg_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0] len_reg, len_next;
  logic [7:0] remain_reg, remain_next;
  logic [7:0] crc_reg, crc_next;
  logic       underrun_reg, underrun_next;
  logic       len_err_reg, len_err_next;

  logic       tx_valid;
  logic       xfer;
  logic       byte_last;
  logic       crc_fb;
  logic [7:0] crc_upd;
  logic       rd_en;

  // Bit-level link status and the CRC value including the bit now on the wire
  always_comb begin
    tx_valid  = (state_reg == ST_PREAMBLE) || (state_reg == ST_SFD) ||
                (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                (state_reg == ST_CRC);
    xfer      = tx_valid && bus.tx_bit_ready;
    byte_last = xfer && (bit_cnt_reg == 3'd7);
    crc_fb    = crc_reg[7] ^ shreg_reg[7];
    crc_upd   = {crc_reg[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
  end

  // State register and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= 8'h00;
      bit_cnt_reg  <= 3'd0;
      pre_cnt_reg  <= 4'd0;
      len_reg      <= 8'h00;
      remain_reg   <= 8'h00;
      crc_reg      <= 8'h00;
      underrun_reg <= 1'b0;
      len_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      bit_cnt_reg  <= bit_cnt_next;
      pre_cnt_reg  <= pre_cnt_next;
      len_reg      <= len_next;
      remain_reg   <= remain_next;
      crc_reg      <= crc_next;
      underrun_reg <= underrun_next;
      len_err_reg  <= len_err_next;
    end
  end

  // Next-state logic: byte sequencing, FIFO fetch, shift and CRC update
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    bit_cnt_next  = bit_cnt_reg;
    pre_cnt_next  = pre_cnt_reg;
    len_next      = len_reg;
    remain_next   = remain_reg;
    crc_next      = crc_reg;
    underrun_next = underrun_reg;
    len_err_next  = 1'b0;
    rd_en         = 1'b0;

    // A transfer always consumes the MSB; the byte-end cases below may reload
    if (xfer) begin
      shreg_next   = {shreg_reg[6:0], 1'b0};
      bit_cnt_next = bit_cnt_reg + 3'd1;
    end
    // Only the length and payload bits are covered by the CRC
    if (xfer && ((state_reg == ST_LEN) || (state_reg == ST_PAYLOAD))) begin
      crc_next = crc_upd;
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.pkt_len > MAX_LEN_B) begin
            len_err_next = 1'b1;
          end else begin
            len_next      = bus.pkt_len;
            remain_next   = bus.pkt_len;
            crc_next      = 8'h00;
            underrun_next = 1'b0;
            pre_cnt_next  = 4'd0;
            bit_cnt_next  = 3'd0;
            shreg_next    = PREAMBLE_BYTE;
            state_next    = ST_PREAMBLE;
          end
        end
      end
      ST_PREAMBLE: begin
        if (byte_last) begin
          if (pre_cnt_reg == PRE_LAST) begin
            shreg_next = SFD;
            state_next = ST_SFD;
          end else begin
            pre_cnt_next = pre_cnt_reg + 4'd1;
            shreg_next   = PREAMBLE_BYTE;
          end
        end
      end
      ST_SFD: begin
        if (byte_last) begin
          shreg_next = len_reg;
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_last) begin
          if (len_reg == 8'h00) begin
            shreg_next = crc_upd;
            state_next = ST_CRC;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (!bus.fifo_empty) begin
          rd_en      = 1'b1;
          state_next = ST_WAIT;
        end else begin
          // Starved mid-frame: abandon without CRC or done
          underrun_next = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        shreg_next = bus.fifo_data;
        state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (byte_last) begin
          remain_next = remain_reg - 8'd1;
          if (remain_reg == 8'd1) begin
            shreg_next = crc_upd;
            state_next = ST_CRC;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_CRC: begin
        if (byte_last) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    bus.fifo_rd_en   = rd_en;
    bus.tx_bit_valid = tx_valid;
    bus.tx_bit       = tx_valid & shreg_reg[7];
    bus.busy         = (state_reg != ST_IDLE);
    bus.done         = (state_reg == ST_FIN);
    bus.underrun     = underrun_reg;
    bus.len_err      = len_err_reg;
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Randomized scoreboard bench for tx_frame_serializer: stimulus pushes the
// expected bit stream built from a byte-level frame model; a negedge monitor
// pops and compares every transferred bit.
`timescale 1ns/1ps
module tb_tx_frame_serializer;
  localparam int PRE  = 4;
  localparam int MAXL = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  tx_frame_serializer_if bus();

  tx_frame_serializer #(
    .PREAMBLE_BYTES(PRE), .SFD(8'hA7), .CRC_POLY(8'h07), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit exp_q[$];
  logic [7:0] pay_q[$];
  int cyc = 0;
  int last_xfer_cyc = -10;
  int done_cnt = 0;
  int len_err_cnt = 0;
  int rd_count = 0;
  logic [7:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic fifo_flush = 1'b0;
  logic bp_mode = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_bit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after the strobe
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_data <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      rd_count <= rd_count + 1;
    end
  end

  // Downstream ready: always ready, or random backpressure
  initial begin
    bus.tx_bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_bit_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare transferred bits, hold stability, done timing
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (prev_stall) begin
        check("stall_valid_held", bus.tx_bit_valid, 1);
        check("stall_bit_held", bus.tx_bit, prev_bit);
      end
      if (bus.tx_bit_valid && bus.tx_bit_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit: got bit %0d expected none", bus.tx_bit);
        end else begin
          check("tx_bit", bus.tx_bit, exp_q.pop_front());
        end
        last_xfer_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        check("done_after_last_bit", cyc - last_xfer_cyc, 1);
      end
      if (bus.len_err) len_err_cnt++;
      prev_stall = bus.tx_bit_valid && !bus.tx_bit_ready;
      prev_bit = bus.tx_bit;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // Byte-wise CRC-8, poly 0x07, init 0
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_valid"}, bus.tx_bit_valid, 0);
    check({tag, "_tx_bit"}, bus.tx_bit, 0);
    check({tag, "_underrun"}, bus.underrun, 0);
    check({tag, "_len_err"}, bus.len_err, 0);
    check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
  endtask

  // Load FIFO, build expected stream, start, wait for done/underrun, check
  task automatic run_frame(input int len, input int n_avail, input bit bp, input bit mid_start);
    int sent, exp_reads, exp_done, rd0, d0;
    bit under, finished;
    logic [7:0] crc;
    @(posedge clk); #1; fifo_flush = 1'b1;
    @(posedge clk); #1; fifo_flush = 1'b0;
    for (int i = 0; i < n_avail; i++) begin
      fifo_mem[wr_ptr] = pay_q[i];
      wr_ptr++;
    end
    under = (n_avail < len);
    sent = under ? n_avail : len;
    exp_reads = sent;
    exp_done = under ? 0 : 1;
    for (int i = 0; i < PRE; i++) push_byte(8'h55);
    push_byte(8'hA7);
    push_byte(8'(len));
    crc = crc_step(8'h00, 8'(len));
    for (int i = 0; i < sent; i++) begin
      push_byte(pay_q[i]);
      crc = crc_step(crc, pay_q[i]);
    end
    if (!under) push_byte(crc);
    rd0 = rd_count;
    d0 = done_cnt;
    bp_mode = bp;
    bus.pkt_len = 8'(len);
    bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", bus.busy, 1);
    check("valid_after_start", bus.tx_bit_valid, 1);
    check("underrun_cleared", bus.underrun, 0);
    if (mid_start) begin
      repeat (20) @(posedge clk);
      #1; bus.pkt_len = 8'd2; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
    end
    finished = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.done || bus.underrun) begin
        finished = 1'b1;
        break;
      end
    end
    check("frame_finished", finished, 1);
    repeat (3) @(negedge clk);
    check("bits_remaining", exp_q.size(), 0);
    check("fifo_reads", rd_count - rd0, exp_reads);
    check("done_pulses", done_cnt - d0, exp_done);
    check("busy_after_frame", bus.busy, 0);
    check("underrun_flag", bus.underrun, under);
    check("valid_after_frame", bus.tx_bit_valid, 0);
    $display("frame len=%0d avail=%0d bp=%0d mid_start=%0d crc=%02h underrun=%0d",
             len, n_avail, bp, mid_start, crc, under);
    bp_mode = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int rd0, d0, le0, len;
    bit got;
    bus.start = 1'b0;
    bus.pkt_len = 8'd0;
    bus.fifo_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    pay_q = '{8'h01, 8'h02, 8'h03};
    run_frame(3, 3, 0, 0);
    run_frame(0, 0, 0, 0);
    pay_q = '{8'h01, 8'h02, 8'h03};
    run_frame(3, 3, 1, 0);
    pay_q = '{8'h01, 8'h02, 8'h03};
    run_frame(3, 1, 0, 0);
    run_frame(0, 0, 0, 0);

    // Oversize length is rejected with a single len_err pulse
    le0 = len_err_cnt;
    @(posedge clk); #1; bus.pkt_len = 8'd65; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("len_err_busy", bus.busy, 0);
    end
    check("len_err_pulses", len_err_cnt - le0, 1);
    $display("len_err pkt_len=65 pulses=%0d", len_err_cnt - le0);

    pay_q = '{8'h01, 8'h02, 8'h03};
    run_frame(3, 3, 0, 1);

    // Reset during payload aborts the frame
    @(posedge clk); #1; fifo_flush = 1'b1;
    @(posedge clk); #1; fifo_flush = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      fifo_mem[wr_ptr] = 8'(i);
      wr_ptr++;
    end
    rd0 = rd_count;
    d0 = done_cnt;
    for (int i = 0; i < PRE; i++) push_byte(8'h55);
    push_byte(8'hA7);
    push_byte(8'h03);
    push_byte(8'h01);
    push_byte(8'h02);
    bus.pkt_len = 8'd3; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (rd_count - rd0 >= 2) begin
        got = 1'b1;
        break;
      end
    end
    check("reached_payload", got, 1);
    repeat (3) @(posedge clk);
    #1; reset = 1'b1; exp_q.delete();
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (100) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    $display("reset mid-frame reads_before_reset=%0d", rd_count - rd0);
    pay_q = '{8'h01, 8'h02, 8'h03};
    run_frame(3, 3, 0, 0);

    // Largest accepted length
    pay_q.delete();
    for (int i = 0; i < MAXL; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    run_frame(MAXL, MAXL, 1, 0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(0, 12);
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
      run_frame(len, len, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_serializer.md
Name: tx_frame_serializer

Overview:
- Downstream consumer of the SPI-loaded TX packet FIFO.
- On a start pulse from the register file, it fetches pkt_len payload bytes from the FIFO and frames them as: preamble, SFD, length byte, payload, CRC-8.
- It shifts the frame out MSB-first as a bit stream, with a valid/ready handshake, to the modulator/DAC stage.

Parameters:
- PREAMBLE_BYTES, 4, number of 0x55 preamble bytes (1..15).
- SFD, 8'hA7, start-of-frame delimiter byte.
- CRC_POLY, 8'h07, CRC-8 polynomial; init 0x00, no reflection, no final XOR.
- MAX_LEN, 64, largest accepted pkt_len.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send a frame.
- pkt_len  in  8  payload byte count; sampled when start is accepted.
- fifo_rd_en  out  1  one-cycle FIFO read strobe.
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO has no data.
- tx_bit  out  1  serial frame bit.
- tx_bit_valid  out  1  tx_bit is valid.
- tx_bit_ready  in  1  downstream accepts the bit; a transfer occurs when valid && ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.
- underrun  out  1  sticky: FIFO was empty when a payload byte was needed.
- len_err  out  1  one-cycle pulse: start rejected because pkt_len > MAX_LEN.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and CRC cleared. Reset mid-frame aborts immediately; nothing more is emitted and done does not pulse.
- FSM states: IDLE, PREAMBLE, SFD, LEN, FETCH, WAIT, PAYLOAD, CRC, FIN.
- IDLE:
  - start with pkt_len <= MAX_LEN: latch pkt_len, clear CRC, clear underrun, set busy, go to PREAMBLE.
  - start with pkt_len > MAX_LEN: pulse len_err, stay in IDLE.
  - start while busy is ignored.
- First tx_bit_valid is asserted the cycle after start is accepted.
- Byte shifting:
  - Each byte is loaded into an 8-bit shift register; tx_bit = shreg[7].
  - A 3-bit counter advances only on a transfer.
  - After bit 0 of a byte transfers, move to the next byte or state.
  - While valid && !ready, tx_bit and the state hold unchanged.
- PREAMBLE: PREAMBLE_BYTES x 0x55, then SFD, then LEN (latched pkt_len).
- After LEN:
  - pkt_len == 0: go to CRC.
  - otherwise: go to FETCH.
- FETCH (tx_bit_valid = 0):
  - fifo_empty = 0: assert fifo_rd_en for exactly one cycle, go to WAIT.
  - fifo_empty = 1: set underrun, clear busy, go to IDLE; no CRC and no done.
- WAIT (tx_bit_valid = 0): load fifo_data into the shift register, go to PAYLOAD.
- Gaps: each payload byte is preceded by a 2-cycle gap where tx_bit_valid = 0. Downstream must tolerate these gaps.
- PAYLOAD: after 8 transfers, decrement the remaining count.
  - count remaining: go to FETCH.
  - count exhausted: go to CRC.
- CRC rules:
  - Updated bitwise, on each transferred bit of LEN and PAYLOAD only.
  - fb = crc[7] ^ bit; crc = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 0).
  - On entering the CRC state, the final CRC value is loaded into the shift register and sent MSB-first.
- FIN: one cycle after the last CRC bit transfers, pulse done, clear busy, return to IDLE.
- Frame length: (PREAMBLE_BYTES + 3 + pkt_len) x 8 bits.
- A new start is accepted in IDLE, at the earliest on the cycle after done.
- underrun stays set until the next accepted start or reset.
- fifo_rd_en never asserts outside FETCH, so at most pkt_len reads occur per frame.

Test Plan:
- Basic frame:
  - Stimulus: reset, load FIFO 01,02,03; start with pkt_len=3; tx_bit_ready held 1.
  - Response: 80 bits = 55 55 55 55 A7 03 01 02 03 72; exactly 3 fifo_rd_en pulses; done one cycle after the last bit; busy low afterwards.
- Zero-length frame:
  - Stimulus: start with pkt_len=0.
  - Response: 56 bits = 55 55 55 55 A7 00 00; no fifo_rd_en; done pulses.
- Backpressure:
  - Stimulus: basic frame with tx_bit_ready toggled pseudo-randomly.
  - Response: identical 80-bit sequence; tx_bit stable whenever valid && !ready.
- Underrun:
  - Stimulus: pkt_len=3 with only 01 in the FIFO.
  - Response: bits through payload byte 01, then underrun=1, busy=0, no CRC, no done.
  - Next start with pkt_len=0 clears underrun.
- Length error:
  - Stimulus: start with pkt_len=65 (MAX_LEN=64).
  - Response: len_err pulses one cycle; busy stays 0; no bits emitted.
  - Start asserted mid-frame is ignored.
- Reset mid-frame:
  - Stimulus: assert reset during the payload.
  - Response: next cycle all outputs 0; a following basic frame matches the basic-frame sequence exactly.
